// File: rtl/seg_count_scan_ctrl_pkg.sv
// Shared definitions for the octal counter / display scan controller:
// control FSM encodings, segment patterns and counter width helper.
package seg_count_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Segment order {a,b,c,d,e,f,g}, active-high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_count_scan_ctrl_seg7_oct_dec.sv
// Combinational 3-bit octal digit to 7-segment decoder, shared by all
// display positions through the scan multiplexer.
module seg7_oct_dec
    import seg_count_scan_ctrl_pkg::*;
(
    input  logic [2:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (digit)
            3'd0: seg = SEG_0;
            3'd1: seg = SEG_1;
            3'd2: seg = SEG_2;
            3'd3: seg = SEG_3;
            3'd4: seg = SEG_4;
            3'd5: seg = SEG_5;
            3'd6: seg = SEG_6;
            3'd7: seg = SEG_7;
        endcase
    end

endmodule

// File: rtl/seg_count_scan_ctrl.sv
// Run/stop controller for a cascaded octal counter with a time-multiplexed
// 7-segment display scanner sharing one decoder across all digits.
module seg_count_scan_ctrl
    import seg_count_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int TICK_DIV   = 50000
)(
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic                    STOP,
    input  logic                    CLEAR,
    output logic [3*NUM_DIGITS-1:0] Q,
    output logic                    RUN,
    output logic                    CARRY,
    output logic [NUM_DIGITS-1:0]   DIG,
    output logic [6:0]              SEG
);

    localparam int TW = cnt_w(TICK_DIV);
    localparam int SW = cnt_w(SCAN_DIV);
    localparam int IW = cnt_w(NUM_DIGITS);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    state_t                state;
    logic [TW-1:0]         tick_cnt;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic [2:0]            digit [NUM_DIGITS];
    logic [NUM_DIGITS:0]   inc;
    logic                  step;
    logic [2:0]            scan_digit;
    logic [6:0]            seg_dec;

    // A STOP or CLEAR on the terminal tick swallows the increment
    assign step   = (state == ST_RUN) && !CLEAR && !STOP && (tick_cnt == TICK_LAST);
    assign inc[0] = step;

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign inc[i+1]     = inc[i] && (digit[i] == 3'd7);
            assign Q[3*i +: 3]  = digit[i];

            always_ff @(posedge CLK) begin
                if (RESET || CLEAR)
                    digit[i] <= 3'd0;
                else if (inc[i])
                    digit[i] <= digit[i] + 3'd1;
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            RUN      <= 1'b0;
            CARRY    <= 1'b0;
            tick_cnt <= '0;
        end else begin
            CARRY <= 1'b0;
            if (CLEAR) begin
                state    <= ST_IDLE;
                RUN      <= 1'b0;
                tick_cnt <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (START && !STOP) begin
                            state    <= ST_RUN;
                            RUN      <= 1'b1;
                            tick_cnt <= '0;
                        end
                    end
                    ST_RUN: begin
                        // tick_cnt is frozen on the STOP edge so HOLD resumes the partial interval
                        if (STOP) begin
                            state <= ST_HOLD;
                            RUN   <= 1'b0;
                        end else begin
                            tick_cnt <= step ? '0 : tick_cnt + TW'(1);
                            CARRY    <= inc[NUM_DIGITS];
                        end
                    end
                    ST_HOLD: begin
                        if (START && !STOP) begin
                            state <= ST_RUN;
                            RUN   <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        RUN   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign scan_digit = digit[scan_idx];

    seg7_oct_dec u_dec (
        .digit (scan_digit),
        .seg   (seg_dec)
    );

    // DIG and SEG share one register stage so a digit never shows a neighbour's pattern
    always_ff @(posedge CLK) begin
        if (RESET) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            DIG      <= '0;
            SEG      <= SEG_BLANK;
        end else begin
            DIG <= NUM_DIGITS'(1) << scan_idx;
            SEG <= seg_dec;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_count_scan_ctrl.sv
// Directed bench for seg_count_scan_ctrl with 2 digits, 4-cycle scan slots
// and a 3-cycle count tick.
module tb_seg_count_scan_ctrl;

    localparam int ND = 2;

    logic          CLK = 1'b0;
    logic          RESET, START, STOP, CLEAR;
    logic [3*ND-1:0] Q;
    logic          RUN, CARRY;
    logic [ND-1:0] DIG;
    logic [6:0]    SEG;

    int n_checks = 0;
    int n_fail   = 0;
    int seen_lo  = 0;
    int seen_hi  = 0;

    seg_count_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (4),
        .TICK_DIV   (3)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .STOP  (STOP),
        .CLEAR (CLEAR),
        .Q     (Q),
        .RUN   (RUN),
        .CARRY (CARRY),
        .DIG   (DIG),
        .SEG   (SEG)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit later
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; STOP = 1'b0; CLEAR = 1'b0;
        cyc(2);
        check("rst_q", Q, 0);
        check("rst_run", RUN, 0);
        check("rst_carry", CARRY, 0);
        check("rst_dig", DIG, 0);
        check("rst_seg", SEG, 0);

        RESET = 1'b0;
        cyc(1);
        check("scan_first_dig", DIG, 2'b01);
        check("scan_first_seg", SEG, 7'b1111110);
        cyc(4);
        check("scan_second_dig", DIG, 2'b10);
        check("scan_second_seg", SEG, 7'b1111110);

        START = 1'b1; cyc(1); START = 1'b0;
        check("start_run", RUN, 1);
        check("start_q0", Q, 0);
        cyc(2);
        check("tick_not_yet", Q, 6'o00);
        cyc(1);
        check("tick_first", Q, 6'o01);
        cyc(3);
        check("tick_second", Q, 6'o02);
        check("no_carry", CARRY, 0);

        cyc(183);
        check("reach_77", Q, 6'o77);
        check("carry_early", CARRY, 0);
        cyc(3);
        check("wrap_q", Q, 6'o00);
        check("wrap_carry", CARRY, 1);
        check("wrap_run", RUN, 1);
        cyc(1);
        check("carry_one_cycle", CARRY, 0);

        // tick_cnt is 1 here
        STOP = 1'b1; cyc(1); STOP = 1'b0;
        check("stop_run", RUN, 0);
        cyc(10);
        check("hold_frozen", Q, 6'o00);
        START = 1'b1; cyc(1); START = 1'b0;
        check("resume_run", RUN, 1);
        cyc(1);
        check("resume_partial", Q, 6'o00);
        cyc(1);
        check("resume_inc", Q, 6'o01);

        cyc(84);
        check("reach_35", Q, 6'o35);
        STOP = 1'b1; cyc(1); STOP = 1'b0;
        check("hold35_q", Q, 6'o35);
        check("hold35_run", RUN, 0);
        START = 1'b1; STOP = 1'b1; CLEAR = 1'b1;
        cyc(1);
        START = 1'b0; STOP = 1'b0; CLEAR = 1'b0;
        check("clear_q", Q, 0);
        check("clear_run", RUN, 0);
        check("clear_carry", CARRY, 0);
        cyc(4);
        check("idle_stays_zero", Q, 0);

        START = 1'b1; cyc(1); START = 1'b0;
        cyc(129);
        check("reach_53", Q, 6'o53);
        STOP = 1'b1; cyc(1); STOP = 1'b0;
        check("hold53_q", Q, 6'o53);
        for (int k = 0; k < 10; k++) begin
            if (DIG == 2'b01) begin
                seen_lo++;
                check("scan_seg_d0", SEG, 7'b1111001);
            end else if (DIG == 2'b10) begin
                seen_hi++;
                check("scan_seg_d1", SEG, 7'b1011011);
            end else begin
                check("scan_dig_onehot", DIG, 2'b01);
            end
            cyc(1);
        end
        check("scan_saw_d0", seen_lo > 0, 1);
        check("scan_saw_d1", seen_hi > 0, 1);

        cyc(1);
        RESET = 1'b1; cyc(1); RESET = 1'b0;
        check("midrst_dig", DIG, 0);
        check("midrst_seg", SEG, 0);
        check("midrst_q", Q, 0);
        check("midrst_run", RUN, 0);
        cyc(1);
        check("midrst_dig_restart", DIG, 2'b01);
        check("midrst_seg_restart", SEG, 7'b1111110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
